// File: rtl/shift_right_seq.sv
// Multi-cycle 32-bit logical/arithmetic right shifter that drives one shared
// single-bit shift slice and assembles the result one bit per cycle.
module shift_right_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             arith,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] slice_x,
  output logic [WIDTH-1:0] slice_y,
  output logic [WIDTH-1:0] slice_i,
  input  logic             slice_z
);

  localparam int unsigned IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLAMP,
    S_SCAN,
    S_DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IW-1:0]  idx;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] z_q;
  logic           arith_q;

  logic           y_big;
  logic           idx_last;
  logic [IW:0]    bit_pos;
  logic           sign_fill;

  // Shift amounts of WIDTH or more never reach the slice; they are clamped.
  assign y_big    = |y[WIDTH-1:IW];
  assign idx_last = (idx == IW'(WIDTH - 1));

  // i > 31 - y[4:0] is the same as i + y[4:0] overflowing the 5-bit range.
  assign bit_pos   = {1'b0, idx} + {1'b0, y_q[IW-1:0]};
  assign sign_fill = arith_q & bit_pos[IW];

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = y_big ? S_CLAMP : S_SCAN;
        end
      end
      S_CLAMP: state_nxt = S_DONE;
      S_SCAN: begin
        if (idx_last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      arith_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            x_q     <= x;
            y_q     <= y;
            arith_q <= arith;
            z_q     <= '0;
            idx     <= '0;
          end
        end
        S_CLAMP: begin
          z_q <= arith_q ? {WIDTH{x_q[WIDTH-1]}} : '0;
        end
        S_SCAN: begin
          z_q[idx] <= sign_fill ? x_q[WIDTH-1] : slice_z;
          // Hold at the last index so the counter never wraps into a 33rd pass.
          if (!idx_last) begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy    = (state == S_CLAMP) || (state == S_SCAN);
    done    = (state == S_DONE);
    z       = z_q;
    slice_x = x_q;
    slice_y = y_q;
    slice_i = '0;
    if (state == S_SCAN) begin
      slice_i[IW-1:0] = idx;
    end
  end

endmodule

// File: tb/tb_shift_right_seq.sv
// Self-checking bench for shift_right_seq with a behavioural slice model and
// a result scoreboard fed at request time and drained on each done pulse.
module tb_shift_right_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] x;
  logic [31:0] y;
  logic        arith;
  logic        busy;
  logic        done;
  logic [31:0] z;
  logic [31:0] slice_x;
  logic [31:0] slice_y;
  logic [31:0] slice_i;
  logic        slice_z;

  int unsigned checks;
  int unsigned failures;
  int unsigned done_count;
  logic [31:0] exp_q[$];

  shift_right_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .x       (x),
    .y       (y),
    .arith   (arith),
    .busy    (busy),
    .done    (done),
    .z       (z),
    .slice_x (slice_x),
    .slice_y (slice_y),
    .slice_i (slice_i),
    .slice_z (slice_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slice behaviour: X[I+Y] when I+Y <= 31, otherwise 0.
  logic [33:0] slice_pos;
  always_comb begin
    slice_pos = {2'b0, slice_i} + {2'b0, slice_y};
    slice_z   = 1'b0;
    if (slice_pos <= 34'd31) begin
      slice_z = slice_x[slice_pos[4:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] s,
                                            input logic ar);
    if (s >= 32) return ar ? {32{a[31]}} : 32'h0;
    if (ar) return 32'($signed(a) >>> s[4:0]);
    return a >> s[4:0];
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_count++;
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd0, 32'd1);
      end else begin
        check("sb_z", z, exp_q.pop_front());
      end
    end
  end

  // Issue one request; optionally re-pulse start or drop reset at cycle k.
  task automatic run_op(input logic [31:0] ax, input logic [31:0] ay, input logic aar,
                        input logic [31:0] exp_z, input int unsigned exp_lat,
                        input int unsigned poke_at, input int unsigned reset_at);
    int unsigned k;
    int unsigned dc0;
    bit seen;
    @(negedge clk);
    x = ax; y = ay; arith = aar; start = 1'b1;
    exp_q.push_back(exp_z);
    dc0 = done_count;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (poke_at != 0 && k == poke_at) begin
        x = 32'hFFFF_FFFF; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (reset_at != 0 && k == reset_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_z", z, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("rst_no_done", done_count, dc0);
        rst_n = 1'b1;
        return;
      end
      if (done) begin
        seen = 1;
        break;
      end
      if (exp_lat == 33) begin
        check("scan_slice_i", slice_i, k - 1);
      end
      check("busy_hi", {31'd0, busy}, 32'd1);
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", k, exp_lat);
      check("busy_in_done", {31'd0, busy}, 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    check("one_done", done_count - dc0, 32'd1);
    check("idle_slice_i", slice_i, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx;
    logic [31:0] ry;
    logic        ra;
    checks = 0; failures = 0; done_count = 0;
    rst_n = 1'b0; start = 1'b0; x = '0; y = '0; arith = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_z", z, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_slice_i", slice_i, 32'd0);
    rst_n = 1'b1;

    run_op(32'h0000_000A, 32'd1,          1'b0, 32'h0000_0005, 33, 0, 0);
    run_op(32'h8000_0000, 32'd4,          1'b1, 32'hF800_0000, 33, 0, 0);
    run_op(32'h0000_000A, 32'd0,          1'b1, 32'h0000_000A, 33, 0, 0);
    run_op(32'h0000_000A, 32'd35,         1'b0, 32'h0000_0000, 2,  0, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF,  1'b1, 32'hFFFF_FFFF, 2,  0, 0);
    run_op(32'h8000_0000, 32'd32,         1'b1, 32'hFFFF_FFFF, 2,  0, 0);
    run_op(32'h8765_4321, 32'd31,         1'b1, 32'hFFFF_FFFF, 33, 0, 0);
    run_op(32'h8765_4321, 32'd31,         1'b0, 32'h0000_0001, 33, 0, 0);
    run_op(32'h0000_000A, 32'd1,          1'b0, 32'h0000_0005, 33, 11, 0);
    run_op(32'h0000_000A, 32'd1,          1'b0, 32'h0000_0005, 33, 0, 16);
    run_op(32'h7FFF_FFFF, 32'd31,         1'b0, 32'h0000_0000, 33, 0, 0);
    run_op(32'h7FFF_FFFF, 32'd31,         1'b1, 32'h0000_0000, 33, 0, 0);

    for (int n = 0; n < 6; n++) begin
      rx = $urandom;
      ry = (n == 5) ? $urandom : 32'($urandom_range(0, 31));
      ra = 1'($urandom_range(0, 1));
      run_op(rx, ry, ra, ref_shift(rx, ry, ra), (ry >= 32) ? 2 : 33, 0, 0);
    end

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);
    check("z_hold", z, exp_q.size() == 0 ? z : 32'hDEAD_BEEF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
